// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output-stage blocks: sink FSM state encoding
// and the default sample width.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sink_state_e;

  localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/fir_stream_sink_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; dout reads as
// zero while empty. Storage carries no reset, only pointers and occupancy do.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pDEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [pDATA_WIDTH-1:0] din,
  input  logic                   pop,
  output logic [pDATA_WIDTH-1:0] dout,
  output logic                   full,
  output logic                   empty
);

  localparam int              AW       = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [AW:0]     OCC_FULL = (AW+1)'(pDEPTH);
  localparam logic [AW-1:0]   PTR_LAST = AW'(pDEPTH - 1);

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            occ;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fir_stream_sink.sv
// FIR result sink: buffers the core's result stream, re-issues it downstream
// with tlast on the final sample of the run, and reports busy/done/out_count.
module fir_stream_sink
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pDEPTH      = 4,
  parameter int pLEN_WIDTH  = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_start,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic                   done,
  output logic [pLEN_WIDTH-1:0]  out_count
);

  sink_state_e           state;
  logic [pLEN_WIDTH-1:0] len_r;
  logic [pLEN_WIDTH-1:0] in_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  // Ready depends only on registered state, never on m_tready.
  assign s_tready = (state == ST_RUN) && !fifo_full;
  assign push     = s_tvalid && s_tready;
  assign m_tvalid = !fifo_empty;
  assign pop      = m_tvalid && m_tready;
  assign m_tlast  = m_tvalid && (out_count == len_r - 1'b1);

  sync_fifo #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_fifo (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .push  (push),
    .din   (s_tdata),
    .pop   (pop),
    .dout  (m_tdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state     <= ST_IDLE;
      len_r     <= '0;
      in_count  <= '0;
      out_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (push) in_count  <= in_count + 1'b1;
      if (pop)  out_count <= out_count + 1'b1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) begin
            len_r     <= cfg_len;
            in_count  <= '0;
            out_count <= '0;
            if (cfg_len == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (push && (in_count + 1'b1 == len_r)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && (out_count + 1'b1 == len_r)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
